uart_tx_fifo_param: RTL and testbench
=====================================

// Module: uart_tx_fifo_param
// PURPOSE
//  Next-generation UART transmitter with an internal TX FIFO, valid/ready input and run-time frame format.
//  Data width 5..9 bits; parity none/even/odd; 1 or 2 stop bits.
//  Sits between the image-processing datapath and the tx pin.
//  Drains queued words as gap-free back-to-back frames, so the producer no longer waits per byte.
// PARAMETERS
//  CLK_FREQ    450_000_000  PLL clock frequency in Hz
//  BAUD_RATE   5_000_000    bit rate; BAUD_DIVISOR = CLK_FREQ/BAUD_RATE, elaboration error if < 2
//  DATA_BITS   8            word width, legal 5..9, elaboration error otherwise
//  FIFO_DEPTH  8            TX FIFO entries, power of 2 and >= 2, elaboration error otherwise
// PORTS
//  clk         in   1                      PLL clock
//  rst_n       in   1                      asynchronous active-low reset
//  s_valid     in   1                      word offered
//  s_ready     out  1                      FIFO not full; push = s_valid & s_ready
//  s_data      in   DATA_BITS              word to send, LSB transmitted first
//  cfg_parity  in   2                      uart_parity_t: 00 none, 01 even, 10 odd, 11 none (reserved)
//  cfg_stop2   in   1                      1 = two stop bits, 0 = one
//  tx          out  1                      serial output, registered, idle high
//  tx_busy     out  1                      state != IDLE or FIFO not empty
//  fifo_level  out  $clog2(FIFO_DEPTH)+1   words in FIFO, range 0..FIFO_DEPTH
//  tx_state    out  uart_txp_state_t       FSM state for debug
// BEHAVIOUR
//  Reset values: tx=1, s_ready=1, tx_busy=0, fifo_level=0, tx_state=IDLE, FIFO emptied.
//  Reset mid-frame aborts the frame; tx returns high asynchronously.
//  FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
//   - IDLE->START: when FIFO is non-empty.
//   - START->DATA: after 1 bit time.
//   - DATA->PARITY: after DATA_BITS bit times, if parity is enabled.
//   - DATA->STOP: after DATA_BITS bit times, if parity is none.
//   - PARITY->STOP: after 1 bit time.
//   - STOP end: go to START if the FIFO is non-empty, else IDLE. No idle gap between queued frames.
//  Bit time is exactly BAUD_DIVISOR clocks.
//   - Baud counter clears on entering START and counts 0..BAUD_DIVISOR-1.
//   - It does not run in IDLE.
//  Latency: push at edge E0 into an empty FIFO while IDLE; at edge E1 pop, load shift reg, state=START, tx=0.
//  Pop occurs only on the IDLE->START or STOP->START transition.
//  cfg_parity and cfg_stop2 are captured at pop. Changes mid-frame affect only the next frame.
//  Parity bit = ^data for even, ~^data for odd, computed over DATA_BITS bits only.
//  Frame length = (1 + DATA_BITS + P + S) * BAUD_DIVISOR clocks, where P = 0/1 and S = 1/2.
//  FIFO:
//   - Simultaneous push and pop leaves fifo_level unchanged.
//   - When full, s_ready=0 and s_data is ignored.
//   - Pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
//  Macro UART_TX_BREAK_EN enables break generation.
//  Defined:
//   - Adds input port send_break (1 bit). It is sampled only in IDLE or at STOP end.
//   - When send_break=1 there, enter BREAK: tx=0, no pop, for as long as send_break stays 1.
//   - On deassertion, hold tx=1 for one full bit time, then go to IDLE. This gives the mark-after-break.
//   - send_break has priority over a non-empty FIFO at a frame boundary.
//  Undefined:
//   - No send_break port.
//   - BREAK remains in the enum but is unreachable. Logic is removed.
// STRUCTURE
//  Shared package uart_types:
//   - uart_parity_t
//   - uart_txp_state_t (IDLE, START, DATA, PARITY, STOP, BREAK)
//   - localparam PARITY_NONE/EVEN/ODD
//  Sub-module uart_tx_sync_fifo: parametrised WIDTH/DEPTH, push/pop/full/empty/level, async active-low reset.
//  Top contains the FSM, baud counter, bit counter, shift register and tx output register.
// TESTING  (CLK_FREQ=100_000_000, BAUD_RATE=10_000_000 -> divisor 10)
//  1. 8N1, push 0xA5 -> tx 0 for 10 clk; bits 1,0,1,0,0,1,0,1 for 10 clk each; stop 10 clk; total 100 clk; tx_busy drops after.
//  2. DATA_BITS=7, even parity, stop2, push 0x41 -> parity bit 0; frame 11 bits = 110 clk.
//  3. 8O1, push 0x00 -> parity bit 1. Change cfg_parity to none mid-frame -> current frame unaffected.
//  4. Hold s_valid=1 with 0x00..0x0A -> s_ready=0 after the 9th accept, level=8.
//     All 11 frames are contiguous (no tx-high cycles between stop and start); 1100 clk total.
//  5. Assert rst_n=0 during data bit 3 -> tx=1 immediately, fifo_level=0, tx_busy=0, tx_state=IDLE.
//     After release, a new push transmits cleanly.
//  6. With UART_TX_BREAK_EN: send_break=1 for 50 clk while idle -> tx low 50 clk, then high >= 10 clk before the next START.
//     A word queued during the break waits until after that.

Source files
------------

// File: rtl/uart_types_pkg.sv
// rtl/uart_types_pkg.sv - shared parity/state types for the buffered UART transmitter
package uart_types;

  typedef logic [1:0] uart_parity_t;

  localparam uart_parity_t PARITY_NONE = 2'b00;
  localparam uart_parity_t PARITY_EVEN = 2'b01;
  localparam uart_parity_t PARITY_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_txp_state_t;

  // The reserved code 11 behaves like no parity.
  function automatic logic parity_enabled(input uart_parity_t mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// rtl/uart_tx_sync_fifo.sv - single-clock FIFO with occupancy count, power-of-2 depth
module uart_tx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// rtl/uart_tx_fifo_param.sv - FIFO-fed UART transmitter with run-time frame format
// Optional break generation is compiled in with UART_TX_BREAK_EN.
module uart_tx_fifo_param
  import uart_types::*;
#(
  parameter int unsigned CLK_FREQ   = 450_000_000,
  parameter int unsigned BAUD_RATE  = 5_000_000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_BITS-1:0]          s_data,
  input  uart_parity_t                  cfg_parity,
  input  logic                          cfg_stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                          send_break,
`endif
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output uart_txp_state_t               tx_state
);

  localparam int unsigned BAUD_DIVISOR = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CW = (BAUD_DIVISOR > 2) ? $clog2(BAUD_DIVISOR) : 1;
  localparam int unsigned BW = $clog2(DATA_BITS);

  if (BAUD_DIVISOR < 2) begin : g_bad_divisor
    $error("uart_tx_fifo_param: BAUD_DIVISOR must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_tx_fifo_param: DATA_BITS must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo_param: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_txp_state_t        state_q, state_d;
  logic [CW-1:0]          baud_q, baud_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
  logic                   stop2_q, stop2_d;
  logic                   tx_q, tx_d;
  logic                   bit_end, frame_end, load_frame, brk_req;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rdata;

`ifdef UART_TX_BREAK_EN
  logic                   brk_mark_q, brk_mark_d;
  assign brk_req = send_break;
`else
  assign brk_req = 1'b0;
`endif

  uart_tx_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (s_valid),
    .data_i  (s_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign s_ready  = ~fifo_full;
  assign tx       = tx_q;
  assign tx_state = state_q;
  assign tx_busy  = (state_q != IDLE) | ~fifo_empty;
  assign bit_end  = (baud_q == CW'(BAUD_DIVISOR - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
`ifdef UART_TX_BREAK_EN
      brk_mark_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
`ifdef UART_TX_BREAK_EN
      brk_mark_q <= brk_mark_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = (state_q == IDLE) ? '0 : (bit_end ? '0 : baud_q + 1'b1);
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    frame_end  = 1'b0;
    load_frame = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_mark_d = brk_mark_q;
`endif
    case (state_q)
      IDLE:    frame_end = 1'b1;
      START:   if (bit_end) begin
                 state_d = DATA;
                 bit_d   = '0;
               end
      DATA:    if (bit_end) begin
                 shreg_d = shreg_q >> 1;
                 if (bit_q == BW'(DATA_BITS - 1)) begin
                   state_d = par_en_q ? PARITY : STOP;
                   bit_d   = '0;
                 end else begin
                   bit_d   = bit_q + 1'b1;
                 end
               end
      PARITY:  if (bit_end) begin
                 state_d = STOP;
                 bit_d   = '0;
               end
      STOP:    if (bit_end) begin
                 if (stop2_q && bit_q == '0) bit_d = 1'b1;
                 else                        frame_end = 1'b1;
               end
`ifdef UART_TX_BREAK_EN
      // Low while the request is held, then one bit time of mark before IDLE.
      BREAK:   if (!brk_mark_q) begin
                 baud_d = '0;
                 if (!send_break) brk_mark_d = 1'b1;
               end else if (bit_end) begin
                 state_d = IDLE;
               end
`endif
      default: state_d = IDLE;
    endcase

    // Frame boundary: break request beats queued data, which beats going idle.
    if (frame_end) begin
      if (brk_req) begin
        state_d = BREAK;
        baud_d  = '0;
`ifdef UART_TX_BREAK_EN
        brk_mark_d = 1'b0;
`endif
      end else if (!fifo_empty) begin
        load_frame = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end

    if (load_frame) begin
      state_d   = START;
      baud_d    = '0;
      shreg_d   = fifo_rdata;
      par_en_d  = parity_enabled(cfg_parity);
      par_bit_d = (cfg_parity == PARITY_ODD) ? ~^fifo_rdata : ^fifo_rdata;
      stop2_d   = cfg_stop2;
    end
  end

  assign fifo_pop = load_frame;

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_bit_q;
`ifdef UART_TX_BREAK_EN
      BREAK:   tx_d = brk_mark_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb/tb_uart_tx_fifo_param.sv - self-checking bench for uart_tx_fifo_param (8-bit and 7-bit instances)
module tb_uart_tx_fifo_param;
  import uart_types::*;

  localparam int DIV = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         va = 1'b0, vb = 1'b0;
  logic         ra, rb;
  logic [8:0]   sdata = '0;
  uart_parity_t cfg_parity = PARITY_NONE;
  logic         cfg_stop2 = 1'b0;
  logic         txa, txb, busya, busyb;
  logic [3:0]   levela;
  logic [2:0]   levelb;
  uart_txp_state_t sta, stb;
`ifdef UART_TX_BREAK_EN
  logic         send_break = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  bit expq[$];

  always #5 clk = ~clk;

  uart_tx_fifo_param #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000),
                       .DATA_BITS(8), .FIFO_DEPTH(8)) u_a (
    .clk(clk), .rst_n(rst_n), .s_valid(va), .s_ready(ra), .s_data(sdata[7:0]),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break),
`endif
    .tx(txa), .tx_busy(busya), .fifo_level(levela), .tx_state(sta));

  uart_tx_fifo_param #(.CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000),
                       .DATA_BITS(7), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .s_valid(vb), .s_ready(rb), .s_data(sdata[6:0]),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
`ifdef UART_TX_BREAK_EN
    .send_break(1'b0),
`endif
    .tx(txb), .tx_busy(busyb), .fifo_level(levelb), .tx_state(stb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start, LSB-first data, optional parity, stop bits; each bit DIV clocks.
  function automatic void add_frame(input logic [8:0] d, input int nbits,
                                    input uart_parity_t p, input bit stop2);
    bit bits[$];
    int ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (p == PARITY_EVEN) bits.push_back(bit'(ones % 2));
    if (p == PARITY_ODD)  bits.push_back(bit'(1 - ones % 2));
    bits.push_back(1'b1);
    if (stop2) bits.push_back(1'b1);
    foreach (bits[i]) for (int c = 0; c < DIV; c++) expq.push_back(bits[i]);
  endfunction

  function automatic logic cur_tx(input bit which);
    return which ? txb : txa;
  endfunction

  task automatic monitor(input bit which, input int chg_at, input uart_parity_t chg_val,
                         output int first);
    first = -1;
    for (int k = 0; k < expq.size(); k++) begin
      @(negedge clk);
      if (k == chg_at) cfg_parity = chg_val;
      if (cur_tx(which) !== expq[k] && first < 0) first = k;
    end
  endtask

  task automatic send_and_check(input string tag, input bit which, input logic [8:0] words[$],
                                input int chg_at, input uart_parity_t chg_val, input int full_at);
    int first;
    int nbits = which ? 7 : 8;
    @(posedge clk); #1;
    expq = {};
    expq.push_back(1'b1);
    expq.push_back(1'b1);
    foreach (words[i]) add_frame(words[i], nbits, cfg_parity, cfg_stop2);
    fork
      begin
        foreach (words[i]) begin
          bit got;
          int n = 0;
          sdata = words[i];
          if (which) vb = 1'b1; else va = 1'b1;
          do begin
            got = which ? rb : ra;
            @(posedge clk); #1;
            n++;
          end while (!got && n < 3000);
          if (!got) chk({tag, "_accept_timeout"}, 32'(n), 32'(0));
          if (full_at == i + 1) begin
            chk({tag, "_level_full"}, 32'(levela), 32'(8));
            chk({tag, "_ready_full"}, 32'(ra), 32'(0));
          end
        end
        va = 1'b0;
        vb = 1'b0;
      end
      monitor(which, chg_at, chg_val, first);
    join
    chk({tag, "_wave_first_bad"}, 32'(first), 32'hFFFF_FFFF);
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(which ? busyb : busya), 32'(0));
    chk({tag, "_idle_after"}, 32'(which ? stb : sta), 32'(IDLE));
  endtask

  initial begin
    logic [8:0] w[$];
    int first;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tx",    32'(txa),    32'(1));
    chk("rst_ready", 32'(ra),     32'(1));
    chk("rst_busy",  32'(busya),  32'(0));
    chk("rst_level", 32'(levela), 32'(0));
    chk("rst_state", 32'(sta),    32'(IDLE));
    chk("rst_b_tx",  32'(txb),    32'(1));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 8N1 0xA5
    cfg_parity = PARITY_NONE; cfg_stop2 = 1'b0;
    w = {9'h0A5};
    send_and_check("t1_8n1", 1'b0, w, -1, PARITY_NONE, 0);

    // 7E2 0x41 on the 7-bit instance
    cfg_parity = PARITY_EVEN; cfg_stop2 = 1'b1;
    w = {9'h041};
    send_and_check("t2_7e2", 1'b1, w, -1, PARITY_NONE, 0);

    // 8O1 0x00, parity switched off mid-frame
    cfg_parity = PARITY_ODD; cfg_stop2 = 1'b0;
    w = {9'h000};
    send_and_check("t3_8o1", 1'b0, w, 40, PARITY_NONE, 0);

    // Back-to-back stream filling the FIFO
    cfg_parity = PARITY_NONE; cfg_stop2 = 1'b0;
    w = {};
    for (int i = 0; i <= 10; i++) w.push_back(9'(i));
    send_and_check("t4_stream", 1'b0, w, -1, PARITY_NONE, 9);

    // Reset during data bit 3
    @(posedge clk); #1;
    sdata = 9'h052; va = 1'b1;
    @(posedge clk); #1; sdata = 9'h053;
    @(posedge clk); #1; sdata = 9'h054;
    @(posedge clk); #1; va = 1'b0;
    repeat (41) @(posedge clk);
    #2;
    chk("t5_in_bit3", 32'(txa), 32'(0));
    chk("t5_level_pre", 32'(levela), 32'(2));
    rst_n = 1'b0;
    #1;
    chk("t5_tx",    32'(txa),    32'(1));
    chk("t5_level", 32'(levela), 32'(0));
    chk("t5_busy",  32'(busya),  32'(0));
    chk("t5_state", 32'(sta),    32'(IDLE));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    w = {9'h03C};
    send_and_check("t5_after", 1'b0, w, -1, PARITY_NONE, 0);

    // Randomized frames and formats
    for (int r = 0; r < 5; r++) begin
      bit which = bit'($urandom_range(0, 1));
      int cnt = $urandom_range(1, 4);
      cfg_parity = uart_parity_t'($urandom_range(0, 3));
      cfg_stop2  = 1'($urandom_range(0, 1));
      w = {};
      for (int i = 0; i < cnt; i++) w.push_back(9'($urandom_range(0, 511)) & (which ? 9'h07F : 9'h0FF));
      send_and_check($sformatf("rand%0d", r), which, w, -1, PARITY_NONE, 0);
    end

`ifdef UART_TX_BREAK_EN
    cfg_parity = PARITY_NONE; cfg_stop2 = 1'b0;
    @(posedge clk); #1;
    expq = {};
    expq.push_back(1'b1);
    for (int i = 0; i < 50; i++) expq.push_back(1'b0);
    for (int i = 0; i < DIV + 1; i++) expq.push_back(1'b1);
    add_frame(9'h0C3, 8, PARITY_NONE, 1'b0);
    fork
      begin
        send_break = 1'b1;
        repeat (10) @(posedge clk);
        #1; sdata = 9'h0C3; va = 1'b1;
        @(posedge clk); #1; va = 1'b0;
        repeat (39) @(posedge clk);
        #1; send_break = 1'b0;
      end
      monitor(1'b0, -1, PARITY_NONE, first);
    join
    chk("t6_break_wave", 32'(first), 32'hFFFF_FFFF);
    @(negedge clk);
    chk("t6_busy_after", 32'(busya), 32'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
